program_counter_nvec: RTL

- Parametrised successor to the current two-vector program counter.
- Computes the next fetch address: PC+offset, register-relative or absolute.
- Supports NUM_INT prioritised, nestable interrupt vectors.
- Return addresses and priority levels are held in a hardware return stack with depth RSTACK_DEPTH; RETI pops the stack.
- Sits between the instruction decoder/sequencer and the memory address path.

---
 rtl/program_counter_nvec_pkg.sv | 28 ++
 rtl/pc_return_stack.sv | 66 ++++++
 rtl/program_counter_nvec.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/program_counter_nvec_pkg.sv
// Shared encodings and helpers for the nested-vector program counter.
package program_counter_nvec_pkg;

  // Base operand select encodings
  localparam logic [1:0] PC_BASEX_PCA     = 2'd0;
  localparam logic [1:0] PC_BASEX_REGB    = 2'd1;
  localparam logic [1:0] PC_BASEX_ZERO    = 2'd2;
  localparam logic [1:0] PC_BASEX_PCA_ALT = 2'd3;

  // Offset operand select encodings
  localparam logic [1:0] PC_OFFSETX_ZERO = 2'd0;
  localparam logic [1:0] PC_OFFSETX_TWO  = 2'd1;
  localparam logic [1:0] PC_OFFSETX_FOUR = 2'd2;
  localparam logic [1:0] PC_OFFSETX_DIN  = 2'd3;

  // Level code meaning "no interrupt active": one past the lowest priority index.
  function automatic int unsigned lvl_none(input int unsigned num_int);
    return num_int;
  endfunction

  // Vector address for interrupt source idx.
  function automatic int unsigned vec_addr(input int unsigned base,
                                           input int unsigned stride,
                                           input int unsigned idx);
    return base + idx * stride;
  endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Hardware return stack holding {return address, interrupted level} pairs.
// The top entry is read combinationally so a RETI can redirect the PC in the
// same fetch that pops it.
module pc_return_stack
  import program_counter_nvec_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LVL_W  = 3,
  parameter int DEPTH  = 4
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        PUSH,
  input  logic                        POP,
  input  logic [ADDR_W-1:0]           PUSH_ADDR,
  input  logic [LVL_W-1:0]            PUSH_LVL,
  output logic [ADDR_W-1:0]           TOP_ADDR,
  output logic [LVL_W-1:0]            TOP_LVL,
  output logic [$clog2(DEPTH+1)-1:0]  CNT,
  output logic                        FULL,
  output logic                        EMPTY
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOTS = 1 << IDX_W;

  logic [ADDR_W-1:0] addr_mem [0:SLOTS-1];
  logic [LVL_W-1:0]  lvl_mem  [0:SLOTS-1];
  logic [CNT_W-1:0]  cnt_reg;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  top_idx;
  logic              do_push;
  logic              do_pop;

  assign FULL    = (cnt_reg == CNT_W'(DEPTH));
  assign EMPTY   = (cnt_reg == '0);
  assign do_push = PUSH & ~FULL;
  assign do_pop  = POP & ~EMPTY;
  assign wr_idx  = IDX_W'(cnt_reg);
  assign top_idx = IDX_W'(cnt_reg - 1'b1);

  assign TOP_ADDR = addr_mem[top_idx];
  assign TOP_LVL  = lvl_mem[top_idx];
  assign CNT      = cnt_reg;

  // Entry storage: contents are don't-care after reset, only the count matters.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      addr_mem[wr_idx] <= PUSH_ADDR;
      lvl_mem[wr_idx]  <= PUSH_LVL;
    end
  end

  // Occupancy counter; push and pop are mutually exclusive at the caller.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_reg <= '0;
    end else if (do_push) begin
      cnt_reg <= cnt_reg + 1'b1;
    end else if (do_pop) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

endmodule

// File: rtl/program_counter_nvec.sv
// Program counter with relative/absolute next-address generation and
// NUM_INT prioritised, nestable interrupt vectors backed by a return stack.
// Control state is implicit: (INT_LVL, RSTACK_CNT) encodes RUN / IN_ISR(level).
module program_counter_nvec
  import program_counter_nvec_pkg::*;
#(
  parameter int                 ADDR_W       = 16,
  parameter int                 NUM_INT      = 4,
  parameter int unsigned        VEC_BASE     = 4,
  parameter int unsigned        VEC_STRIDE   = 4,
  parameter int                 RSTACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0]  RESET_ADDR   = {{(ADDR_W-1){1'b1}}, 1'b0}
) (
  input  logic                               CLK,
  input  logic                               RESET,
  input  logic                               FETCH,
  input  logic                               PC_ENX,
  input  logic [1:0]                         PC_BASEX,
  input  logic [1:0]                         PC_OFFSETX,
  input  logic [ADDR_W-1:0]                  REGB_DOUT,
  input  logic [ADDR_W-1:0]                  DIN,
  input  logic [NUM_INT-1:0]                 INT_REQ,
  input  logic                               INT_EN,
  input  logic                               RETI,
  output logic [ADDR_W-1:0]                  PC_A,
  output logic [ADDR_W-1:0]                  PC_A_NEXT,
  output logic [ADDR_W-1:0]                  HERE,
  output logic [NUM_INT-1:0]                 INT_ACK,
  output logic [$clog2(NUM_INT+1)-1:0]       INT_LVL,
  output logic [$clog2(RSTACK_DEPTH+1)-1:0]  RSTACK_CNT,
  output logic                               STK_OVF,
  output logic                               STK_UDF
);

  localparam int LVL_W = $clog2(NUM_INT + 1);
  localparam int CNT_W = $clog2(RSTACK_DEPTH + 1);
  localparam logic [LVL_W-1:0] LVL_NONE = LVL_W'(lvl_none(NUM_INT));

  logic [ADDR_W-1:0]  pc_a_reg;
  logic [ADDR_W-1:0]  here_reg;
  logic [NUM_INT-1:0] int_ack_reg;
  logic [LVL_W-1:0]   int_lvl_reg;
  logic               stk_ovf_reg;
  logic               stk_udf_reg;

  logic [ADDR_W-1:0]  arg_a;
  logic [ADDR_W-1:0]  arg_b;
  logic [ADDR_W-1:0]  sum;
  logic [ADDR_W-1:0]  vec_target;
  logic [ADDR_W-1:0]  pc_next;
  logic [NUM_INT-1:0] eligible;
  logic               win_valid;
  logic [LVL_W-1:0]   win_idx;
  logic               upd;
  logic               reti_upd;
  logic               take;
  logic               blocked_full;

  logic [ADDR_W-1:0]  top_addr;
  logic [LVL_W-1:0]   top_lvl;
  logic [CNT_W-1:0]   stk_cnt;
  logic               stk_full;
  logic               stk_empty;

  assign upd      = FETCH & PC_ENX;
  assign reti_upd = upd & RETI;

  // A source may preempt only when it is strictly higher priority than the active level.
  generate
    for (genvar gi = 0; gi < NUM_INT; gi++) begin : g_elig
      assign eligible[gi] = INT_REQ[gi] & (LVL_W'(gi) < int_lvl_reg);
    end
  endgenerate

  // Pick the lowest eligible index as the winner.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_valid = 1'b1;
        win_idx   = LVL_W'(i);
      end
    end
  end

  assign take         = upd & INT_EN & win_valid & ~RETI & ~stk_full;
  assign blocked_full = upd & INT_EN & win_valid & ~RETI & stk_full;
  assign vec_target   = ADDR_W'(vec_addr(VEC_BASE, VEC_STRIDE, 32'(win_idx)));

  // Base/offset selection and the silently wrapping sequential sum.
  always_comb begin
    arg_a = pc_a_reg;
    arg_b = '0;
    case (PC_BASEX)
      PC_BASEX_REGB: arg_a = REGB_DOUT;
      PC_BASEX_ZERO: arg_a = '0;
      default:       arg_a = pc_a_reg;
    endcase
    case (PC_OFFSETX)
      PC_OFFSETX_TWO:  arg_b = ADDR_W'(2);
      PC_OFFSETX_FOUR: arg_b = ADDR_W'(4);
      PC_OFFSETX_DIN:  arg_b = DIN;
      default:         arg_b = '0;
    endcase
    sum = arg_a + arg_b;
  end

  // Next address: a real pop beats a vector, which beats the sequential sum.
  always_comb begin
    pc_next = sum;
    if (reti_upd && !stk_empty) begin
      pc_next = top_addr;
    end else if (take) begin
      pc_next = vec_target;
    end
  end

  pc_return_stack #(
    .ADDR_W (ADDR_W),
    .LVL_W  (LVL_W),
    .DEPTH  (RSTACK_DEPTH)
  ) u_rstack (
    .CLK       (CLK),
    .RESET     (RESET),
    .PUSH      (take),
    .POP       (reti_upd),
    .PUSH_ADDR (sum),
    .PUSH_LVL  (int_lvl_reg),
    .TOP_ADDR  (top_addr),
    .TOP_LVL   (top_lvl),
    .CNT       (stk_cnt),
    .FULL      (stk_full),
    .EMPTY     (stk_empty)
  );

  // Architectural registers: PC, HERE, active level, acknowledge and sticky flags.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_a_reg    <= RESET_ADDR;
      here_reg    <= '0;
      int_ack_reg <= '0;
      int_lvl_reg <= LVL_NONE;
      stk_ovf_reg <= 1'b0;
      stk_udf_reg <= 1'b0;
    end else begin
      int_ack_reg <= '0;
      if (upd) begin
        pc_a_reg <= pc_next;
        here_reg <= pc_next + ADDR_W'(2);
        if (RETI) begin
          if (!stk_empty) begin
            int_lvl_reg <= top_lvl;
          end else begin
            stk_udf_reg <= 1'b1;
          end
        end else if (take) begin
          int_lvl_reg <= win_idx;
          int_ack_reg <= NUM_INT'(1) << win_idx;
        end else if (blocked_full) begin
          stk_ovf_reg <= 1'b1;
        end
      end
    end
  end

  assign PC_A       = pc_a_reg;
  assign PC_A_NEXT  = pc_next;
  assign HERE       = here_reg;
  assign INT_ACK    = int_ack_reg;
  assign INT_LVL    = int_lvl_reg;
  assign RSTACK_CNT = stk_cnt;
  assign STK_OVF    = stk_ovf_reg;
  assign STK_UDF    = stk_udf_reg;

endmodule
